cbx_param_cfg: RTL and testbench

- Parametrised X-channel connection block with a glitch-free configuration chain.
- Passes CHAN_W tracks straight through in each direction.
- Drives NUM_IPIN grid input pins. Each pin has a full-crossbar mux over all 2*CHAN_W tracks.
- Mux selects load serially through a ccff shift chain into a shadow register. They commit atomically to the active register only when a complete frame has been shifted in, so pins never see partial configurations.
- Sits between routing channel and bottom grid IO/CLB, and chains with neighbouring blocks through ccff_head/ccff_tail.

---
 rtl/cbx_param_cfg.sv | 135 +++++++++++++
 tb/tb_cbx_param_cfg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cbx_param_cfg.sv
// cbx_param_cfg -- parametrised X-channel connection block.
// Straight pass-through of CHAN_W tracks in each direction. Each of NUM_IPIN
// grid input pins is driven by a full crossbar over all 2*CHAN_W tracks.
// Pin selects are shifted in serially on the ccff chain into a shadow
// register. They are copied to the active register only when a complete
// frame has arrived, so the pins never see a partial configuration.
// Optional feature: define CBX_CFG_PARITY_EN to append one even-parity bit
// to every frame. A frame with bad parity is rejected and flagged on the
// sticky cfg_err output.
module cbx_param_cfg #(
  parameter int CHAN_W   = 3,
  parameter int NUM_IPIN = 2
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  input  logic                ccff_head,
  input  logic                ccff_en,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_valid,
  output logic                cfg_busy,
  output logic                cfg_err
);

  localparam int SEL_W = $clog2(2*CHAN_W+1);
`ifdef CBX_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SEL_BITS = NUM_IPIN*SEL_W;
  localparam int CFG_BITS = SEL_BITS + PAR_W;
  localparam int CNT_W    = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS-1);
  localparam logic [SEL_W-1:0] NUM_TRK  = SEL_W'(2*CHAN_W);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [SEL_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tail_q, tail_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [CFG_BITS-1:0] frame;
  logic [2*CHAN_W-1:0] tracks;
  logic [SEL_W-1:0]    sel;

  // Routing-channel pass-through, independent of the configuration.
  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  // Track numbering: left tracks first, right tracks above them.
  assign tracks = {chanx_right_in, chanx_left_in};

  // Chain shift, frame counting and atomic commit into the active register.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    shadow_d = shadow_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    valid_d  = valid_q;
    err_d    = err_q;
    frame    = {shadow_q[CFG_BITS-2:0], ccff_head};
    if (ccff_en) begin
      shadow_d = frame;
      tail_d   = shadow_q[CFG_BITS-1];
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
`ifdef CBX_CFG_PARITY_EN
        if (^frame) begin
          err_d = 1'b1;
        end else begin
          active_d = frame[CFG_BITS-1:PAR_W];
          valid_d  = 1'b1;
          err_d    = 1'b0;
        end
`else
        active_d = frame[CFG_BITS-1:PAR_W];
        valid_d  = 1'b1;
        err_d    = 1'b0;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Configuration state registers; reset discards any partial frame.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      tail_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, whatever the statement order.
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Per-pin crossbar; out-of-range selects and an unconfigured block give 0.
  always_comb begin
    ipin_out = '0;
    sel      = '0;
    for (int k = 0; k < NUM_IPIN; k++) begin
      sel = active_q[k*SEL_W +: SEL_W];
      if (valid_q && (sel < NUM_TRK)) begin
        ipin_out[k] = tracks[sel];
      end
    end
  end

  assign ccff_tail = tail_q;
  assign cfg_valid = valid_q;
  assign cfg_busy  = (cnt_q != '0);
`ifdef CBX_CFG_PARITY_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Directed testbench for cbx_param_cfg in its default build
// (CHAN_W=3, NUM_IPIN=2, SEL_W=3, CFG_BITS=6, no parity bit).
module tb_cbx_param_cfg;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n;
  logic [2:0] chanx_left_in, chanx_right_in;
  logic [2:0] chanx_left_out, chanx_right_out;
  logic       ccff_head, ccff_en;
  logic [1:0] ipin_out;
  logic       ccff_tail, cfg_valid, cfg_busy, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Frames, shifted MSB first. F1: pin1 sel=5, pin0 sel=0.
  // F2: pin1 sel=2, pin0 sel=3. F7: both pins select 7 (out of range).
  localparam logic [5:0] F1 = 6'b101_000;
  localparam logic [5:0] F2 = 6'b010_011;
  localparam logic [5:0] F7 = 6'b111_111;

  cbx_param_cfg #(.CHAN_W(3), .NUM_IPIN(2)) dut (
    .prog_clk        (prog_clk),
    .prog_reset_n    (prog_reset_n),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .ccff_head       (ccff_head),
    .ccff_en         (ccff_en),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ipin_out        (ipin_out),
    .ccff_tail       (ccff_tail),
    .cfg_valid       (cfg_valid),
    .cfg_busy        (cfg_busy),
    .cfg_err         (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One prog_clk edge with the given enable/data; returns 1 time unit after it.
  task automatic clk_edge(input logic en, input logic b);
    ccff_en   = en;
    ccff_head = b;
    @(posedge prog_clk);
    #1;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic set_tracks(input logic [2:0] l, input logic [2:0] r);
    chanx_left_in  = l;
    chanx_right_in = r;
    #1;
  endtask

  initial begin
    logic [5:0] f;
    prog_reset_n = 1'b0;
    ccff_en      = 1'b0;
    ccff_head    = 1'b0;
    set_tracks(3'b101, 3'b010);
    repeat (2) @(posedge prog_clk);
    #1;

    // Reset state and pass-through.
    check("rst_right_out", 32'(chanx_right_out), 32'h5);
    check("rst_left_out",  32'(chanx_left_out),  32'h2);
    check("rst_ipin",      32'(ipin_out),        32'h0);
    check("rst_valid",     32'(cfg_valid),       32'h0);
    check("rst_busy",      32'(cfg_busy),        32'h0);
    check("rst_tail",      32'(ccff_tail),       32'h0);
    check("rst_err",       32'(cfg_err),         32'h0);
    prog_reset_n = 1'b1;

    // Continuous load of F1 with all tracks high.
    set_tracks(3'b111, 3'b111);
    f = F1;
    for (int i = 5; i >= 0; i--) begin
      clk_edge(1'b1, f[i]);
      if (i > 0) begin
        check("load_busy",  32'(cfg_busy),  32'h1);
        check("load_valid", 32'(cfg_valid), 32'h0);
        check("load_ipin",  32'(ipin_out),  32'h0);
        check("load_tail",  32'(ccff_tail), 32'h0);
      end
    end
    check("commit_valid", 32'(cfg_valid), 32'h1);
    check("commit_busy",  32'(cfg_busy),  32'h0);
    set_tracks(3'b001, 3'b100);
    check("f1_ipin_11", 32'(ipin_out), 32'h3);
    set_tracks(3'b001, 3'b000);
    check("f1_ipin_01", 32'(ipin_out), 32'h1);
    set_tracks(3'b110, 3'b011);
    check("f1_ipin_00",   32'(ipin_out),        32'h0);
    check("pass_right",   32'(chanx_right_out), 32'h6);
    check("pass_left",    32'(chanx_left_out),  32'h3);

    // Idle edges with ccff_en low must not disturb anything.
    set_tracks(3'b001, 3'b100);
    repeat (3) clk_edge(1'b0, 1'b1);
    check("idle_valid", 32'(cfg_valid), 32'h1);
    check("idle_busy",  32'(cfg_busy),  32'h0);
    check("idle_ipin",  32'(ipin_out),  32'h3);

    // Paused load: 3 bits, 10 disabled edges, 3 bits.
    prog_reset_n = 1'b0;
    #1;
    check("rst2_ipin",  32'(ipin_out),  32'h0);
    check("rst2_valid", 32'(cfg_valid), 32'h0);
    prog_reset_n = 1'b1;
    for (int i = 5; i >= 3; i--) clk_edge(1'b1, f[i]);
    check("pause_busy_a", 32'(cfg_busy), 32'h1);
    repeat (10) clk_edge(1'b0, 1'b1);
    check("pause_busy_b",  32'(cfg_busy),  32'h1);
    check("pause_valid",   32'(cfg_valid), 32'h0);
    check("pause_ipin",    32'(ipin_out),  32'h0);
    clk_edge(1'b1, f[2]);
    clk_edge(1'b1, f[1]);
    check("pause_valid5", 32'(cfg_valid), 32'h0);
    check("pause_ipin5",  32'(ipin_out),  32'h0);
    clk_edge(1'b1, f[0]);
    check("pause_valid6", 32'(cfg_valid), 32'h1);
    check("pause_busy6",  32'(cfg_busy),  32'h0);
    check("pause_ipin6",  32'(ipin_out),  32'h3);

    // Reload in ACTIVE with all-ones: old frame drives pins and shifts out.
    f = F7;
    for (int i = 5; i >= 0; i--) begin
      clk_edge(1'b1, f[i]);
      check("reload_tail", 32'(ccff_tail), 32'(F1[i]));
      if (i > 0) begin
        check("reload_ipin_old", 32'(ipin_out),  32'h3);
        check("reload_busy",     32'(cfg_busy),  32'h1);
        check("reload_valid",    32'(cfg_valid), 32'h1);
      end
    end
    check("sel7_ipin_a", 32'(ipin_out), 32'h0);
    set_tracks(3'b111, 3'b111);
    check("sel7_ipin_b", 32'(ipin_out), 32'h0);
    check("sel7_busy",   32'(cfg_busy), 32'h0);

    // Load F2: pin1 -> track 2 (left[2]), pin0 -> track 3 (right[0]).
    set_tracks(3'b100, 3'b001);
    f = F2;
    for (int i = 5; i >= 0; i--) begin
      clk_edge(1'b1, f[i]);
      check("f2_tail", 32'(ccff_tail), 32'h1);
    end
    check("f2_ipin_11", 32'(ipin_out), 32'h3);
    set_tracks(3'b000, 3'b001);
    check("f2_ipin_01", 32'(ipin_out), 32'h1);
    set_tracks(3'b100, 3'b000);
    check("f2_ipin_10", 32'(ipin_out), 32'h2);

    // Reset in the middle of a frame.
    set_tracks(3'b100, 3'b001);
    clk_edge(1'b1, 1'b0);
    clk_edge(1'b1, 1'b1);
    clk_edge(1'b1, 1'b1);
    clk_edge(1'b1, 1'b0);
    check("mid_busy", 32'(cfg_busy), 32'h1);
    check("mid_ipin", 32'(ipin_out), 32'h3);
    prog_reset_n = 1'b0;
    #1;
    check("mid_rst_ipin",  32'(ipin_out),  32'h0);
    check("mid_rst_valid", 32'(cfg_valid), 32'h0);
    check("mid_rst_busy",  32'(cfg_busy),  32'h0);
    check("mid_rst_tail",  32'(ccff_tail), 32'h0);
    #1;
    prog_reset_n = 1'b1;
    f = F1;
    set_tracks(3'b001, 3'b100);
    for (int i = 5; i >= 0; i--) begin
      clk_edge(1'b1, f[i]);
      check("post_rst_tail", 32'(ccff_tail), 32'h0);
    end
    check("post_rst_valid", 32'(cfg_valid), 32'h1);
    check("post_rst_ipin",  32'(ipin_out),  32'h3);
    check("post_rst_err",   32'(cfg_err),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
